// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: sequencer between the EX stage and the multi-cycle FPU core.
// Accepts one FP operation at a time, registers the operands, issues a
// single-cycle one-hot opcode, waits for the core result and holds result and
// flags until the MEM-side consumer takes them.
// Optional feature macro: FPU_WATCHDOG_EN (WAIT-state watchdog that aborts
// with res_flags = 4'b1000 after TIMEOUT_CYCLES cycles without a result).
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic [9:0]  fpu_opcode,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    input  logic [31:0] fpu_y,
    input  logic        fpu_ovf,
    input  logic        fpu_unf,
    input  logic        fpu_out_valid,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [3:0]  res_flags,
    input  logic        res_ready,
    output logic        spurious_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // alu_control codes, entry gi selects fpu_opcode bit gi
    localparam logic [49:0] OP_TABLE = {
        5'b11000, 5'b11001, 5'b10101, 5'b10111, 5'b10110,
        5'b11011, 5'b10011, 5'b10010, 5'b10001, 5'b10000
    };

    // Counter must be able to hold TIMEOUT_CYCLES-1; reject impossible setups
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 ||
        (CNT_W < 32 && TIMEOUT_CYCLES > (32'd1 << CNT_W))) begin : g_bad_param
        $error("fpu_issue_ctrl: TIMEOUT_CYCLES out of range for CNT_W");
    end

    state_t      state_reg, state_next;
    logic [9:0]  onehot_reg, onehot_next;
    logic [31:0] x1_reg, x1_next;
    logic [31:0] x2_reg, x2_next;
    logic [31:0] data_reg, data_next;
    logic [2:0]  flags_reg, flags_next;      // {illegal, unf, ovf}
    logic        spurious_reg, spurious_next;
    logic [9:0]  dec_onehot;
    logic        op_legal;

`ifdef FPU_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic             timeout_reg, timeout_next;
`endif

    // Decode alu_control into the one-hot core opcode, one comparator per bit
    for (genvar gi = 0; gi < 10; gi++) begin : g_dec
        assign dec_onehot[gi] = (req_op == OP_TABLE[gi*5 +: 5]);
    end

    assign op_legal = |dec_onehot;

    // Outputs are registers or pure state decodes; nothing flows from req_*/res_ready
    assign req_ready    = (state_reg == ST_IDLE);
    assign res_valid    = (state_reg == ST_HOLD);
    assign fpu_opcode   = (state_reg == ST_ISSUE) ? onehot_reg : 10'd0;
    assign fpu_x1       = x1_reg;
    assign fpu_x2       = x2_reg;
    assign res_data     = data_reg;
    assign spurious_err = spurious_reg;
`ifdef FPU_WATCHDOG_EN
    assign res_flags    = {timeout_reg, flags_reg};
`else
    assign res_flags    = {1'b0, flags_reg};
`endif

    // Next-state and datapath-next logic for the issue sequencer
    always_comb begin
        state_next    = state_reg;
        onehot_next   = onehot_reg;
        x1_next       = x1_reg;
        x2_next       = x2_reg;
        data_next     = data_reg;
        flags_next    = flags_reg;
        // A core result is only expected while waiting for one
        spurious_next = spurious_reg | (fpu_out_valid && (state_reg != ST_WAIT));
`ifdef FPU_WATCHDOG_EN
        wd_cnt_next   = wd_cnt_reg;
        timeout_next  = timeout_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (req_valid && req_op[4]) begin
                    if (op_legal) begin
                        x1_next     = req_a;
                        x2_next     = req_b;
                        onehot_next = dec_onehot;
                        state_next  = ST_ISSUE;
                    end else begin
                        data_next  = 32'd0;
                        flags_next = 3'b100;
`ifdef FPU_WATCHDOG_EN
                        timeout_next = 1'b0;
`endif
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_ISSUE: begin
`ifdef FPU_WATCHDOG_EN
                wd_cnt_next = '0;
`endif
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef FPU_WATCHDOG_EN
                wd_cnt_next = wd_cnt_reg + 1'b1;
`endif
                if (fpu_out_valid) begin
                    // A result arriving on the expiry cycle still wins
                    data_next  = fpu_y;
                    flags_next = {1'b0, fpu_unf, fpu_ovf};
`ifdef FPU_WATCHDOG_EN
                    timeout_next = 1'b0;
`endif
                    state_next = ST_HOLD;
                end
`ifdef FPU_WATCHDOG_EN
                else if (wd_cnt_reg == WD_LAST) begin
                    data_next    = 32'd0;
                    flags_next   = 3'b000;
                    timeout_next = 1'b1;
                    state_next   = ST_HOLD;
                end
`endif
            end
            ST_HOLD: begin
                // No bypass: the next request waits for IDLE
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand, opcode, result and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_reg   <= 10'd0;
            x1_reg       <= 32'd0;
            x2_reg       <= 32'd0;
            data_reg     <= 32'd0;
            flags_reg    <= 3'd0;
            spurious_reg <= 1'b0;
`ifdef FPU_WATCHDOG_EN
            wd_cnt_reg   <= '0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
            onehot_reg   <= onehot_next;
            x1_reg       <= x1_next;
            x2_reg       <= x2_next;
            data_reg     <= data_next;
            flags_reg    <= flags_next;
            spurious_reg <= spurious_next;
`ifdef FPU_WATCHDOG_EN
            wd_cnt_reg   <= wd_cnt_next;
            timeout_reg  <= timeout_next;
`endif
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: stimulus pushes expected opcodes and
// results into queues, a monitor pops and compares them as the DUT presents
// them, and a small FPU model answers issued opcodes.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [4:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        req_ready;
    logic [9:0]  fpu_opcode;
    logic [31:0] fpu_x1, fpu_x2;
    logic [31:0] fpu_y;
    logic        fpu_ovf, fpu_unf, fpu_out_valid;
    logic        res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic        res_ready;
    logic        spurious_err;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
        .fpu_y(fpu_y), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
        .fpu_out_valid(fpu_out_valid),
        .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags),
        .res_ready(res_ready), .spurious_err(spurious_err)
    );

    typedef struct { logic [9:0] op; logic [31:0] a; logic [31:0] b; } op_t;
    typedef struct { logic [31:0] data; logic [3:0] flags; } res_t;
    typedef struct { logic [31:0] y; logic unf; logic ovf; } resp_t;

    op_t   op_q[$];
    res_t  res_q[$];
    resp_t resp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit model_en;
    int model_lat;
    int pulse_cnt;
    int pulse_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; waited = cycles spent stalled
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit keep, output int waited);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 200) begin
            tick(1);
            waited++;
        end
        if (!req_ready) check("send_timeout_req_ready", {31'd0, req_ready}, 32'd1);
        else tick(1);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 200) begin
            tick(1);
            n++;
        end
        if (!res_valid) check("res_valid_timeout", {31'd0, res_valid}, 32'd1);
    endtask

    // FPU core model: answers an issued opcode after model_lat cycles, or fires
    // a stray pulse when the stimulus asks for one
    initial begin
        resp_t r;
        fpu_out_valid = 1'b0; fpu_y = 32'd0; fpu_unf = 1'b0; fpu_ovf = 1'b0;
        pulse_seen = 0;
        forever begin
            @(negedge clk);
            if (fpu_opcode != 10'd0 && model_en && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                repeat (model_lat) @(posedge clk);
                #1;
                fpu_y = r.y; fpu_unf = r.unf; fpu_ovf = r.ovf; fpu_out_valid = 1'b1;
                @(posedge clk); #1;
                fpu_out_valid = 1'b0; fpu_unf = 1'b0; fpu_ovf = 1'b0;
            end else if (pulse_cnt != pulse_seen) begin
                @(posedge clk); #1;
                fpu_y = 32'hDEADBEEF; fpu_out_valid = 1'b1;
                @(posedge clk); #1;
                fpu_out_valid = 1'b0;
                pulse_seen++;
            end
        end
    end

    // Monitor: pops expected opcode/operands on issue, expected result on handshake,
    // and checks operands stay put while waiting on the core
    initial begin
        op_t  eo;
        res_t er;
        logic [31:0] wait_x1, wait_x2;
        wait_x1 = 32'd0; wait_x2 = 32'd0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (fpu_opcode != 10'd0) begin
                if (op_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_opcode: got 0x%03h required none", fpu_opcode);
                end else begin
                    eo = op_q.pop_front();
                    $display("[TB] issue opcode=0x%03h x1=0x%08h x2=0x%08h", fpu_opcode, fpu_x1, fpu_x2);
                    check("issue_opcode", {22'd0, fpu_opcode}, {22'd0, eo.op});
                    check("issue_x1", fpu_x1, eo.a);
                    check("issue_x2", fpu_x2, eo.b);
                    wait_x1 = eo.a; wait_x2 = eo.b;
                end
            end else if (!req_ready && !res_valid) begin
                check("wait_x1_stable", fpu_x1, wait_x1);
                check("wait_x2_stable", fpu_x2, wait_x2);
            end
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_result: got data 0x%08h flags 0x%h required none", res_data, res_flags);
                end else begin
                    er = res_q.pop_front();
                    $display("[TB] result data=0x%08h flags=%b", res_data, res_flags);
                    check("result_data", res_data, er.data);
                    check("result_flags", {28'd0, res_flags}, {28'd0, er.flags});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int n;
        rst = 1'b1; req_valid = 1'b0; req_op = 5'd0; req_a = 32'd0; req_b = 32'd0;
        res_ready = 1'b0; model_en = 1'b1; model_lat = 1; pulse_cnt = 0;
        tick(3);
        rst = 1'b0;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_opcode", {22'd0, fpu_opcode}, 32'd0);
        check("rst_x1", fpu_x1, 32'd0);
        check("rst_x2", fpu_x2, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_flags", {28'd0, res_flags}, 32'd0);
        check("rst_spurious", {31'd0, spurious_err}, 32'd0);

        // 1: FADD-style op, core latency 5
        res_ready = 1'b1; model_lat = 5;
        resp_q.push_back('{32'h40400000, 1'b0, 1'b0});
        op_q.push_back('{10'h001, 32'h3F800000, 32'h40000000});
        res_q.push_back('{32'h40400000, 4'h0});
        send(5'b10000, 32'h3F800000, 32'h40000000, 1'b0, w);
        check("t1_opcode_pulse", {22'd0, fpu_opcode}, 32'h001);
        tick(1);
        check("t1_opcode_one_cycle", {22'd0, fpu_opcode}, 32'd0);
        // HOLD is entered 6 edges after acceptance (ISSUE + 5 WAIT); one already elapsed
        wait_res(n);
        check("t1_res_latency", n, 32'd5);
        tick(1);
        check("t1_res_valid_one_cycle", {31'd0, res_valid}, 32'd0);
        check("t1_req_ready_back", {31'd0, req_ready}, 32'd1);

        // 2: consumer stalls for 10 cycles; result must hold
        res_ready = 1'b0; model_lat = 2;
        resp_q.push_back('{32'hC0A00000, 1'b0, 1'b1});
        op_q.push_back('{10'h200, 32'h11111111, 32'h22222222});
        res_q.push_back('{32'hC0A00000, 4'b0001});
        send(5'b11000, 32'h11111111, 32'h22222222, 1'b0, w);
        wait_res(n);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", {31'd0, res_valid}, 32'd1);
            check("t2_hold_data", res_data, 32'hC0A00000);
            check("t2_hold_flags", {28'd0, res_flags}, 32'b0001);
            check("t2_hold_req_ready", {31'd0, req_ready}, 32'd0);
            tick(1);
        end
        res_ready = 1'b1;
        tick(1);
        check("t2_release_idle", {31'd0, req_ready}, 32'd1);
        check("t2_release_res_valid", {31'd0, res_valid}, 32'd0);

        // 3: illegal FP code goes straight to HOLD; non-FP code is ignored
        res_q.push_back('{32'd0, 4'b0100});
        send(5'b10100, 32'hAAAAAAAA, 32'h55555555, 1'b0, w);
        check("t3_illegal_res_valid", {31'd0, res_valid}, 32'd1);
        check("t3_illegal_data", res_data, 32'd0);
        check("t3_illegal_flags", {28'd0, res_flags}, 32'b0100);
        check("t3_illegal_no_opcode", {22'd0, fpu_opcode}, 32'd0);
        tick(1);
        check("t3_illegal_back_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = 5'b00011;
        tick(2);
        check("t3_nonfp_req_ready", {31'd0, req_ready}, 32'd1);
        check("t3_nonfp_res_valid", {31'd0, res_valid}, 32'd0);
        check("t3_nonfp_opcode", {22'd0, fpu_opcode}, 32'd0);
        req_valid = 1'b0;

`ifdef FPU_WATCHDOG_EN
        // 4: core never answers; abort after 8 WAIT cycles, late pulse is spurious
        model_en = 1'b0;
        op_q.push_back('{10'h002, 32'h00000005, 32'h00000006});
        res_q.push_back('{32'd0, 4'b1000});
        send(5'b10001, 32'h00000005, 32'h00000006, 1'b0, w);
        wait_res(n);
        check("t4_timeout_latency", n, 32'd9);
        check("t4_timeout_flags", {28'd0, res_flags}, 32'b1000);
        tick(1);
        check("t4_spurious_before", {31'd0, spurious_err}, 32'd0);
        pulse_cnt++;
        tick(3);
        check("t4_spurious_late", {31'd0, spurious_err}, 32'd1);
        model_en = 1'b1;
`endif

        // 5: reset in WAIT, then stray result after reset
        model_en = 1'b0;
        op_q.push_back('{10'h004, 32'h01234567, 32'h89ABCDEF});
        send(5'b10010, 32'h01234567, 32'h89ABCDEF, 1'b0, w);
        tick(2);
        check("t5_in_wait", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("t5_rst_opcode", {22'd0, fpu_opcode}, 32'd0);
        check("t5_rst_x1", fpu_x1, 32'd0);
        check("t5_rst_x2", fpu_x2, 32'd0);
        check("t5_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("t5_rst_res_flags", {28'd0, res_flags}, 32'd0);
        check("t5_rst_spurious", {31'd0, spurious_err}, 32'd0);
        pulse_cnt++;
        tick(3);
        check("t5_spurious_set", {31'd0, spurious_err}, 32'd1);
        check("t5_still_idle", {31'd0, req_ready}, 32'd1);
        check("t5_no_result", {31'd0, res_valid}, 32'd0);
        model_en = 1'b1; model_lat = 1;
        resp_q.push_back('{32'h12345678, 1'b1, 1'b0});
        op_q.push_back('{10'h008, 32'h00000003, 32'h00000004});
        res_q.push_back('{32'h12345678, 4'b0010});
        send(5'b10011, 32'h00000003, 32'h00000004, 1'b0, w);
        wait_res(n);
        tick(1);
        check("t5_recovered_idle", {31'd0, req_ready}, 32'd1);

        // 6: back-to-back with req_valid held; second waits for ISSUE+3 WAIT+HOLD
        model_lat = 3;
        resp_q.push_back('{32'hAAAA0001, 1'b0, 1'b0});
        resp_q.push_back('{32'hBBBB0002, 1'b0, 1'b1});
        op_q.push_back('{10'h010, 32'h00000011, 32'h00000012});
        op_q.push_back('{10'h020, 32'h00000021, 32'h00000022});
        res_q.push_back('{32'hAAAA0001, 4'b0000});
        res_q.push_back('{32'hBBBB0002, 4'b0001});
        send(5'b11011, 32'h00000011, 32'h00000012, 1'b1, w);
        send(5'b10110, 32'h00000021, 32'h00000022, 1'b1, w);
        check("t6_second_accept_stall", w, 32'd5);
        req_valid = 1'b0;
        wait_res(n);
        tick(2);

        check("sb_results_drained", res_q.size(), 32'd0);
        check("sb_opcodes_drained", op_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
